// File: rtl/riscv_ctrl_pkg.sv
// Shared control-word layout, forward-select codes and stage bundles
// for the ID/EX/MEM/WB control pipeline.
package riscv_ctrl_pkg;

  localparam int CTRL_W     = 9;
  localparam int BRANCH     = 8;
  localparam int MEM_TO_REG = 7;
  localparam int REG_WRITE  = 6;
  localparam int MEM_READ   = 5;
  localparam int MEM_WRITE  = 4;
  localparam int ALU_SRC    = 3;
  localparam int ALU_OP_HI  = 2;
  localparam int ALU_OP_LO  = 0;

  // Field positions inside the narrowed MEM control word
  localparam int M_MEM_TO_REG = 3;
  localparam int M_REG_WRITE  = 2;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  localparam logic [CTRL_W-1:0] BUBBLE  = '0;
  localparam logic [15:0]       CNT_MAX = 16'hFFFF;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
  } id_ex_t;

  typedef struct packed {
    logic [4:0] ctrl;
    logic [4:0] rd;
  } ex_mem_t;

  typedef struct packed {
    logic [1:0] ctrl;
    logic [4:0] rd;
  } mem_wb_t;

  localparam id_ex_t ID_EX_BUBBLE = '{
    ctrl: BUBBLE, rs1: 5'd0, rs2: 5'd0, rd: 5'd0
  };

  function automatic logic hit(
    input logic [4:0] rd,
    input logic [4:0] rs
  );
    return (rd != 5'd0) && (rd == rs);
  endfunction

  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic       mem_rw,
    input logic [4:0] mem_rd,
    input logic       wb_rw,
    input logic [4:0] wb_rd
  );
    if (mem_rw && hit(mem_rd, rs))
      return FWD_MEM;
    else if (wb_rw && hit(wb_rd, rs))
      return FWD_WB;
    else
      return FWD_RF;
  endfunction

endpackage

// File: rtl/ctrl_pipeline_if.sv
// ID-side request and per-stage control outputs of ctrl_pipeline.
// master drives the decoded ID instruction, slave is the pipeline.
interface ctrl_pipeline_if;
  import riscv_ctrl_pkg::*;

  logic [CTRL_W-1:0] Ctrl_i;
  logic [4:0]        Rs1_i;
  logic [4:0]        Rs2_i;
  logic [4:0]        Rd_i;
  logic              Flush_i;
  logic              Stall_o;
  logic [CTRL_W-1:0] EX_Ctrl_o;
  logic [4:0]        EX_Rs1_o;
  logic [4:0]        EX_Rs2_o;
  logic [4:0]        EX_Rd_o;
  logic [4:0]        MEM_Ctrl_o;
  logic [4:0]        MEM_Rd_o;
  logic [1:0]        WB_Ctrl_o;
  logic [4:0]        WB_Rd_o;
  logic [1:0]        Forward_A_o;
  logic [1:0]        Forward_B_o;
  logic [15:0]       Stall_Count_o;

  modport master (
    output Ctrl_i, Rs1_i, Rs2_i, Rd_i, Flush_i,
    input  Stall_o, EX_Ctrl_o, EX_Rs1_o, EX_Rs2_o,
    input  EX_Rd_o, MEM_Ctrl_o, MEM_Rd_o,
    input  WB_Ctrl_o, WB_Rd_o,
    input  Forward_A_o, Forward_B_o, Stall_Count_o
  );

  modport slave (
    input  Ctrl_i, Rs1_i, Rs2_i, Rd_i, Flush_i,
    output Stall_o, EX_Ctrl_o, EX_Rs1_o, EX_Rs2_o,
    output EX_Rd_o, MEM_Ctrl_o, MEM_Rd_o,
    output WB_Ctrl_o, WB_Rd_o,
    output Forward_A_o, Forward_B_o, Stall_Count_o
  );

endinterface

// File: rtl/ctrl_pipeline_hazard_unit.sv
// Combinational load-use / RAW stall detection and operand forwarding.
// Forwarding muxes exist only with CTRL_PIPELINE_FORWARDING_EN.
module hazard_unit
  import riscv_ctrl_pkg::*;
(
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic       flush,
  input  logic [4:0] ex_rd,
  input  logic       ex_mem_read,
`ifdef CTRL_PIPELINE_FORWARDING_EN
  input  logic [4:0] ex_rs1,
  input  logic [4:0] ex_rs2,
  input  logic [4:0] wb_rd,
  input  logic       wb_reg_write,
`else
  input  logic       ex_reg_write,
`endif
  input  logic [4:0] mem_rd,
  input  logic       mem_reg_write,
  output logic       stall,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b
);

  logic ex_use;
  logic load_use;
  logic raw;

  always_comb begin
    ex_use   = hit(ex_rd, rs1) || hit(ex_rd, rs2);
    load_use = ex_mem_read && ex_use;
`ifdef CTRL_PIPELINE_FORWARDING_EN
    raw   = 1'b0;
    fwd_a = fwd_sel(ex_rs1, mem_reg_write, mem_rd,
                    wb_reg_write, wb_rd);
    fwd_b = fwd_sel(ex_rs2, mem_reg_write, mem_rd,
                    wb_reg_write, wb_rd);
`else
    // No bypass: wait until the producer reaches WB
    raw   = (ex_reg_write && ex_use) ||
            (mem_reg_write &&
             (hit(mem_rd, rs1) || hit(mem_rd, rs2)));
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
`endif
    stall = !flush && (load_use || raw);
  end

endmodule

// File: rtl/ctrl_pipeline.sv
// ID->EX->MEM->WB control/index pipeline with hazard stall and counter.
// Define CTRL_PIPELINE_FORWARDING_EN to build in EX operand forwarding.
module ctrl_pipeline
  import riscv_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  ctrl_pipeline_if.slave  bus
);

  id_ex_t      ex_q;
  id_ex_t      ex_d;
  ex_mem_t     mem_q;
  mem_wb_t     wb_q;
  logic [15:0] stall_cnt_q;
  logic [15:0] stall_cnt_d;
  logic        hz_stall;
  logic        stall;
  logic [1:0]  fwd_a;
  logic [1:0]  fwd_b;

  hazard_unit u_hazard (
    .rs1           (bus.Rs1_i),
    .rs2           (bus.Rs2_i),
    .flush         (bus.Flush_i),
    .ex_rd         (ex_q.rd),
    .ex_mem_read   (ex_q.ctrl[MEM_READ]),
`ifdef CTRL_PIPELINE_FORWARDING_EN
    .ex_rs1        (ex_q.rs1),
    .ex_rs2        (ex_q.rs2),
    .wb_rd         (wb_q.rd),
    .wb_reg_write  (wb_q.ctrl[0]),
`else
    .ex_reg_write  (ex_q.ctrl[REG_WRITE]),
`endif
    .mem_rd        (mem_q.rd),
    .mem_reg_write (mem_q.ctrl[M_REG_WRITE]),
    .stall         (hz_stall),
    .fwd_a         (fwd_a),
    .fwd_b         (fwd_b)
  );

  assign stall = reset && hz_stall;

  always_comb begin
    ex_d = '{ctrl: bus.Ctrl_i, rs1: bus.Rs1_i,
             rs2: bus.Rs2_i, rd: bus.Rd_i};
    if (stall || bus.Flush_i)
      ex_d = ID_EX_BUBBLE;
    stall_cnt_d = stall_cnt_q;
    if (stall && stall_cnt_q != CNT_MAX)
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_q        <= ID_EX_BUBBLE;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= '{ctrl: ex_q.ctrl[BRANCH:MEM_WRITE],
                       rd:   ex_q.rd};
      wb_q        <= '{ctrl: mem_q.ctrl[M_MEM_TO_REG:M_REG_WRITE],
                       rd:   mem_q.rd};
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.Stall_o       = stall;
  assign bus.EX_Ctrl_o     = ex_q.ctrl;
  assign bus.EX_Rs1_o      = ex_q.rs1;
  assign bus.EX_Rs2_o      = ex_q.rs2;
  assign bus.EX_Rd_o       = ex_q.rd;
  assign bus.MEM_Ctrl_o    = mem_q.ctrl;
  assign bus.MEM_Rd_o      = mem_q.rd;
  assign bus.WB_Ctrl_o     = wb_q.ctrl;
  assign bus.WB_Rd_o       = wb_q.rd;
  assign bus.Forward_A_o   = fwd_a;
  assign bus.Forward_B_o   = fwd_b;
  assign bus.Stall_Count_o = stall_cnt_q;

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Randomized + directed bench for ctrl_pipeline against a stage-list model.
// Expectations follow CTRL_PIPELINE_FORWARDING_EN when it is defined.
module tb_ctrl_pipeline;

`ifdef CTRL_PIPELINE_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  localparam logic [8:0] NOP = 9'h000;
  localparam logic [8:0] LD  = 9'h0E0;
  localparam logic [8:0] ALU = 9'h042;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ctrl_pipeline_if bus ();

  ctrl_pipeline dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [8:0] c;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
  } ins_t;

  // pipe[0]=EX, pipe[1]=MEM, pipe[2]=WB, full instructions
  ins_t pipe [3];
  int   m_cnt;
  bit   m_held;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   on = 1'b0;

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", n, a, e, $time);
    end
  endtask

  function automatic bit reads(input ins_t p, input logic [4:0] a,
                               input logic [4:0] b);
    return p.rd != 5'd0 && (p.rd == a || p.rd == b);
  endfunction

  function automatic bit exp_stall();
    bit h;
    if (reset !== 1'b1 || bus.Flush_i) return 1'b0;
    h = pipe[0].c[5] && reads(pipe[0], bus.Rs1_i, bus.Rs2_i);
    for (int s = 0; s < 2; s++)
      if (!FWD && pipe[s].c[6] && reads(pipe[s], bus.Rs1_i, bus.Rs2_i))
        h = 1'b1;
    return h;
  endfunction

  function automatic logic [1:0] exp_fwd(input logic [4:0] r);
    for (int s = 1; s < 3; s++)
      if (FWD && pipe[s].c[6] && pipe[s].rd != 5'd0 && pipe[s].rd == r)
        return (s == 1) ? 2'b10 : 2'b01;
    return 2'b00;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < 3; s++) pipe[s] = '0;
      m_cnt  = 0;
      m_held = 1'b0;
    end else begin
      m_held = exp_stall();
      if (m_held && m_cnt < 65535) m_cnt++;
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      if (m_held || bus.Flush_i) pipe[0] = '0;
      else pipe[0] = '{bus.Ctrl_i, bus.Rs1_i, bus.Rs2_i, bus.Rd_i};
    end
  end

  always @(negedge clk) if (on) begin
    chk("stall",    32'(bus.Stall_o),       32'(exp_stall()));
    chk("ex_ctrl",  32'(bus.EX_Ctrl_o),     32'(pipe[0].c));
    chk("ex_rs1",   32'(bus.EX_Rs1_o),      32'(pipe[0].rs1));
    chk("ex_rs2",   32'(bus.EX_Rs2_o),      32'(pipe[0].rs2));
    chk("ex_rd",    32'(bus.EX_Rd_o),       32'(pipe[0].rd));
    chk("mem_ctrl", 32'(bus.MEM_Ctrl_o),    32'(pipe[1].c[8:4]));
    chk("mem_rd",   32'(bus.MEM_Rd_o),      32'(pipe[1].rd));
    chk("wb_ctrl",  32'(bus.WB_Ctrl_o),     32'(pipe[2].c[7:6]));
    chk("wb_rd",    32'(bus.WB_Rd_o),       32'(pipe[2].rd));
    chk("fwd_a",    32'(bus.Forward_A_o),   32'(exp_fwd(pipe[0].rs1)));
    chk("fwd_b",    32'(bus.Forward_B_o),   32'(exp_fwd(pipe[0].rs2)));
    chk("cnt",      32'(bus.Stall_Count_o), 32'(m_cnt[15:0]));
  end

  task automatic id(input logic [8:0] c, input logic [4:0] a,
                    input logic [4:0] b, input logic [4:0] d,
                    input logic f);
    @(posedge clk); #1;
    bus.Ctrl_i  = c;
    bus.Rs1_i   = a;
    bus.Rs2_i   = b;
    bus.Rd_i    = d;
    bus.Flush_i = f;
    @(negedge clk); #2;
  endtask

  task automatic nops(input int n);
    repeat (n) id(NOP, 5'd0, 5'd0, 5'd0, 1'b0);
  endtask

  task automatic chk_zero(input string n);
    chk({n, "_stall"}, 32'(bus.Stall_o), 32'd0);
    chk({n, "_exc"},   32'(bus.EX_Ctrl_o), 32'd0);
    chk({n, "_exrd"},  32'(bus.EX_Rd_o), 32'd0);
    chk({n, "_memc"},  32'(bus.MEM_Ctrl_o), 32'd0);
    chk({n, "_wbc"},   32'(bus.WB_Ctrl_o), 32'd0);
    chk({n, "_fa"},    32'(bus.Forward_A_o), 32'd0);
    chk({n, "_cnt"},   32'(bus.Stall_Count_o), 32'd0);
  endtask

  initial begin
    bus.Ctrl_i  = NOP;
    bus.Rs1_i   = 5'd0;
    bus.Rs2_i   = 5'd0;
    bus.Rd_i    = 5'd0;
    bus.Flush_i = 1'b0;
    reset = 1'b1;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    #2 chk_zero("rst");
    reset = 1'b1;
    on = 1'b1;
    nops(3);

    // load rd=5 in EX, consumer rs1=5 in ID
    id(LD, 5'd0, 5'd0, 5'd5, 1'b0);
    id(ALU, 5'd5, 5'd7, 5'd6, 1'b0);
    chk("ldu_stall", 32'(bus.Stall_o), 32'd1);
    chk("ldu_cnt0", 32'(bus.Stall_Count_o), 32'd0);
    id(ALU, 5'd5, 5'd7, 5'd6, 1'b0);
    chk("ldu_bub", 32'(bus.EX_Ctrl_o), 32'd0);
    chk("ldu_cnt1", 32'(bus.Stall_Count_o), 32'd1);
    chk("ldu_stall2", 32'(bus.Stall_o), FWD ? 32'd0 : 32'd1);
    if (!FWD) begin
      id(ALU, 5'd5, 5'd7, 5'd6, 1'b0);
      chk("ldu_stall3", 32'(bus.Stall_o), 32'd0);
      chk("ldu_cnt2", 32'(bus.Stall_Count_o), 32'd2);
    end

    // flush overrides load-use
    nops(3);
    id(LD, 5'd0, 5'd0, 5'd5, 1'b0);
    id(ALU, 5'd5, 5'd0, 5'd6, 1'b1);
    chk("fl_stall", 32'(bus.Stall_o), 32'd0);
    id(NOP, 5'd0, 5'd0, 5'd0, 1'b0);
    chk("fl_bub", 32'(bus.EX_Ctrl_o), 32'd0);
    chk("fl_cnt", 32'(bus.Stall_Count_o), FWD ? 32'd1 : 32'd2);

    // R-type rd=3 then consumer rs1=3
    nops(3);
    id(ALU, 5'd1, 5'd2, 5'd3, 1'b0);
    id(ALU, 5'd3, 5'd2, 5'd4, 1'b0);
    chk("raw_stall1", 32'(bus.Stall_o), FWD ? 32'd0 : 32'd1);
    if (!FWD) begin
      id(ALU, 5'd3, 5'd2, 5'd4, 1'b0);
      chk("raw_stall2", 32'(bus.Stall_o), 32'd1);
      id(ALU, 5'd3, 5'd2, 5'd4, 1'b0);
      chk("raw_stall3", 32'(bus.Stall_o), 32'd0);
    end
    id(NOP, 5'd0, 5'd0, 5'd0, 1'b0);
    chk("raw_exrd", 32'(bus.EX_Rd_o), 32'd4);
    chk("raw_fa", 32'(bus.Forward_A_o), FWD ? 32'd2 : 32'd0);
    chk("raw_cnt", 32'(bus.Stall_Count_o), FWD ? 32'd1 : 32'd4);

    // x0 is never a hazard
    nops(3);
    id(LD, 5'd0, 5'd0, 5'd0, 1'b0);
    id(ALU, 5'd0, 5'd0, 5'd1, 1'b0);
    chk("x0_stall", 32'(bus.Stall_o), 32'd0);
    id(NOP, 5'd0, 5'd0, 5'd0, 1'b0);
    chk("x0_fa", 32'(bus.Forward_A_o), 32'd0);

    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      if (!m_held) begin
        bus.Ctrl_i = 9'($urandom);
        bus.Rs1_i  = 5'($urandom_range(0, 3));
        bus.Rs2_i  = 5'($urandom_range(0, 3));
        bus.Rd_i   = 5'($urandom_range(0, 3));
      end
      bus.Flush_i = ($urandom_range(0, 7) == 0);
    end

    // counter saturation from a preloaded value
    nops(3);
    force dut.stall_cnt_q = 16'hFFFD;
    m_cnt = 65533;
    @(posedge clk); #1;
    release dut.stall_cnt_q;
    for (int k = 0; k < 3; k++) begin
      id(LD, 5'd0, 5'd0, 5'd5, 1'b0);
      repeat (2) id(ALU, 5'd5, 5'd0, 5'd6, 1'b0);
      nops(2);
    end
    chk("sat_cnt", 32'(bus.Stall_Count_o), 32'hFFFF);

    // reset asserted while a stall is active
    id(LD, 5'd0, 5'd0, 5'd5, 1'b0);
    id(ALU, 5'd5, 5'd0, 5'd6, 1'b0);
    chk("mid_stall", 32'(bus.Stall_o), 32'd1);
    #1 reset = 1'b0;
    #1 chk_zero("mid_rst");
    @(negedge clk); #2 reset = 1'b1;
    nops(3);

    on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
